// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: multi-channel SAR ADC sequencer with sample/hold, binary search and per-channel averaging
module sar_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  parameter int AVG_LOG2 = 0,
  parameter int SAMPLE_CYCLES = 2,
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic             cont,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             comp_in,
  output logic             sh_clk,
  output logic [CHW-1:0]   mux_sel,
  output logic [WIDTH-1:0] sar_out,
  output logic [WIDTH-1:0] result,
  output logic [CHW-1:0]   result_ch,
  output logic             valid,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;
  state_t state;
  logic [NCH-1:0] mask_l;
  logic cont_l;
  logic [3:0] cnt;
  logic [3:0] nconv;
  logic [WIDTH+AVG_LOG2-1:0] acc, acc_sum;
  logic [WIDTH-1:0] bit_k, code;
  logic [CHW-1:0] lo_new, lo_l, nxt;
  logic has_nxt;
  function automatic logic [CHW-1:0] lowest(input logic [NCH-1:0] m);
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--) if (m[i]) lowest = CHW'(i);
  endfunction
  // trial-bit decision, accumulation and channel sequencing helpers
  always_comb begin
    bit_k = WIDTH'(1) << cnt;
    code = comp_in ? sar_out : sar_out & ~bit_k;
    acc_sum = acc + (WIDTH + AVG_LOG2)'(code);
    lo_new = lowest(ch_mask);
    lo_l = lowest(mask_l);
    nxt = '0;
    has_nxt = 1'b0;
    for (int i = NCH - 1; i >= 0; i--)
      if (mask_l[i] && CHW'(i) > mux_sel) begin
        nxt = CHW'(i);
        has_nxt = 1'b1;
      end
  end
  // scan FSM; mux_sel doubles as the current channel register, cnt as sample counter and bit index
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state <= IDLE;
      sh_clk <= 1'b0;
      mux_sel <= '0;
      sar_out <= '0;
      result <= '0;
      result_ch <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
      acc <= '0;
      nconv <= '0;
      cnt <= '0;
      mask_l <= '0;
      cont_l <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && |ch_mask) begin
          state <= SAMPLE;
          mask_l <= ch_mask;
          cont_l <= cont;
          mux_sel <= lo_new;
          sh_clk <= 1'b1;
          busy <= 1'b1;
          cnt <= 4'(SAMPLE_CYCLES - 1);
        end
        SAMPLE: if (cnt == 4'd0) begin
          state <= CONVERT;
          sh_clk <= 1'b0;
          sar_out <= WIDTH'(1) << (WIDTH - 1);
          cnt <= 4'(WIDTH - 1);
        end else cnt <= cnt - 4'd1;
        CONVERT: if (cnt != 4'd0) begin
          sar_out <= code | (bit_k >> 1);
          cnt <= cnt - 4'd1;
        end else if (nconv == 4'((1 << AVG_LOG2) - 1)) begin
          state <= DONE;
          sar_out <= '0;
          valid <= 1'b1;
          result <= WIDTH'(acc_sum >> AVG_LOG2);
          result_ch <= mux_sel;
          acc <= '0;
          nconv <= '0;
        end else begin
          state <= SAMPLE;
          sar_out <= '0;
          sh_clk <= 1'b1;
          acc <= acc_sum;
          nconv <= nconv + 4'd1;
          cnt <= 4'(SAMPLE_CYCLES - 1);
        end
        DONE: begin
          valid <= 1'b0;
          if (has_nxt || cont_l) begin
            state <= SAMPLE;
            sh_clk <= 1'b1;
            mux_sel <= has_nxt ? nxt : lo_l;
            cnt <= 4'(SAMPLE_CYCLES - 1);
          end else begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sar_scan_ctrl.sv
// tb_sar_scan_ctrl: directed self-checking bench for sar_scan_ctrl with comparator models
module tb_sar_scan_ctrl;
  logic clk = 1'b0, reset_in = 1'b1, start = 1'b0, cont = 1'b0;
  logic [3:0] ch_mask = 4'b0;
  logic comp, comp2, sh_clk, sh_clk2, valid, valid2, busy, busy2;
  logic [1:0] mux_sel, mux_sel2, result_ch, result_ch2;
  logic [7:0] sar_out, sar_out2, result, result2;
  logic [7:0] vin [4];
  logic [7:0] held = 8'h0, held2 = 8'h0;
  logic [7:0] seq [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
  logic [7:0] trial [8] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
  int k2 = 0;
  logic sh2_d = 1'b0, valid_d = 1'b0, mon_sel = 1'b0;
  int checks = 0, errors = 0, dbl = 0, bad_sel = 0;

  sar_scan_ctrl dut (.clk(clk), .reset_in(reset_in), .start(start), .cont(cont), .ch_mask(ch_mask),
    .comp_in(comp), .sh_clk(sh_clk), .mux_sel(mux_sel), .sar_out(sar_out), .result(result),
    .result_ch(result_ch), .valid(valid), .busy(busy));
  sar_scan_ctrl #(.AVG_LOG2(2)) dut2 (.clk(clk), .reset_in(reset_in), .start(start), .cont(cont),
    .ch_mask(ch_mask), .comp_in(comp2), .sh_clk(sh_clk2), .mux_sel(mux_sel2), .sar_out(sar_out2),
    .result(result2), .result_ch(result_ch2), .valid(valid2), .busy(busy2));

  always #5 clk = ~clk;
  assign comp = held >= sar_out;
  assign comp2 = held2 >= sar_out2;

  always @(negedge clk) begin
    if (sh_clk) held <= vin[mux_sel];
    if (valid && valid_d) dbl <= dbl + 1;
    valid_d <= valid;
    if (mon_sel && sh_clk && !mux_sel[0]) bad_sel <= bad_sel + 1;
  end

  always @(negedge clk) begin
    if (reset_in) k2 <= 0;
    else if (sh_clk2 && !sh2_d) begin
      held2 <= seq[k2[1:0]];
      k2 <= k2 + 1;
    end
    sh2_d <= sh_clk2;
  end

  task automatic do_reset();
    @(negedge clk) reset_in = 1'b1; start = 1'b0;
    @(negedge clk) reset_in = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk) reset_in = 1'b1; start = 1'b1; ch_mask = 4'b0001;
    @(negedge clk) reset_in = 1'b0; start = 1'b0;
    checks++;
    if ({sh_clk, mux_sel, sar_out, result, result_ch, valid, busy} !== 22'b0) begin
      errors++;
      $display("FAIL reset_vals got %b exp 0", {sh_clk, mux_sel, sar_out, result, result_ch, valid, busy});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_over_start busy got %b exp 0", busy); end
  endtask

  task automatic test_single();
    vin[0] = 8'h5A; ch_mask = 4'b0001; cont = 1'b0;
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (c <= 2 && {sh_clk, sar_out, mux_sel, valid} !== {1'b1, 8'h00, 2'd0, 1'b0}) begin
        errors++; $display("FAIL single_sample c%0d got sh=%b sar=%h sel=%0d v=%b", c, sh_clk, sar_out, mux_sel, valid);
      end
      if (c >= 3 && c <= 10 && {sh_clk, sar_out, valid} !== {1'b0, trial[c-3], 1'b0}) begin
        errors++; $display("FAIL single_trial c%0d got sh=%b sar=%h v=%b exp sar=%h", c, sh_clk, sar_out, valid, trial[c-3]);
      end
      if (c == 11 && {valid, result, result_ch, busy} !== {1'b1, 8'h5A, 2'd0, 1'b1}) begin
        errors++; $display("FAIL single_done got v=%b res=%h ch=%0d exp v=1 res=5a ch=0", valid, result, result_ch);
      end
      if (c == 12 && {busy, valid, result} !== {1'b0, 1'b0, 8'h5A}) begin
        errors++; $display("FAIL single_idle got busy=%b v=%b res=%h exp 0 0 5a", busy, valid, result);
      end
      if (c < 12) @(negedge clk);
    end
  endtask

  task automatic test_mask();
    int n;
    do_reset();
    vin[0] = 8'h33; vin[1] = 8'h00; vin[2] = 8'h77; vin[3] = 8'hFF;
    ch_mask = 4'b1010; cont = 1'b0; mon_sel = 1'b1;
    pulse_start();
    n = 0;
    while (!valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if ({valid, result, result_ch} !== {1'b1, 8'h00, 2'd1}) begin
      errors++; $display("FAIL mask_ch1 got v=%b res=%h ch=%0d exp 1 00 1", valid, result, result_ch);
    end
    @(negedge clk); n = 0;
    while (!valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if ({valid, result, result_ch} !== {1'b1, 8'hFF, 2'd3}) begin
      errors++; $display("FAIL mask_ch3 got v=%b res=%h ch=%0d exp 1 ff 3", valid, result, result_ch);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mask_end busy got %b exp 0", busy); end
    mon_sel = 1'b0;
    checks++;
    if (bad_sel !== 0) begin errors++; $display("FAIL mask_sel got %0d samples on ch0/2 exp 0", bad_sel); end
  endtask

  task automatic test_cont();
    int n, bl;
    logic [7:0] exp_res;
    do_reset();
    vin[0] = 8'h21; vin[1] = 8'hC4; ch_mask = 4'b0011; cont = 1'b1;
    pulse_start();
    cont = 1'b0; ch_mask = 4'b1100; bl = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      if (i > 0) @(negedge clk);
      if (i == 1) start = 1'b1;
      while (!valid && n < 40) begin
        if (!busy) bl++;
        @(negedge clk); n++;
        start = 1'b0;
      end
      exp_res = (i % 2 == 0) ? 8'h21 : 8'hC4;
      checks++;
      if ({valid, result, result_ch} !== {1'b1, exp_res, 2'(i % 2)}) begin
        errors++; $display("FAIL cont_seq%0d got v=%b res=%h ch=%0d exp 1 %h %0d", i, valid, result, result_ch, exp_res, i % 2);
      end
    end
    checks++;
    if (bl !== 0 || busy !== 1'b1) begin errors++; $display("FAIL cont_busy got %0d low cycles exp 0", bl); end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int nv;
    do_reset();
    vin[0] = 8'h5A; ch_mask = 4'b0001; cont = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk);
    checks++;
    if (sar_out !== 8'h50) begin errors++; $display("FAIL mid_bit4 got sar=%h exp 50", sar_out); end
    reset_in = 1'b1;
    @(negedge clk) reset_in = 1'b0;
    checks++;
    if ({sh_clk, mux_sel, sar_out, result, result_ch, valid, busy} !== 22'b0) begin
      errors++;
      $display("FAIL mid_reset got %b exp 0", {sh_clk, mux_sel, sar_out, result, result_ch, valid, busy});
    end
    nv = 0;
    repeat (15) begin @(negedge clk); if (valid || busy) nv++; end
    checks++;
    if (nv !== 0) begin errors++; $display("FAIL mid_quiet got %0d active cycles exp 0", nv); end
    test_single();
  endtask

  task automatic test_zero_mask();
    int na;
    do_reset();
    ch_mask = 4'b0000; start = 1'b1; na = 0;
    repeat (50) begin @(negedge clk); if (busy || valid) na++; end
    start = 1'b0;
    checks++;
    if (na !== 0) begin errors++; $display("FAIL zero_mask got %0d active cycles exp 0", na); end
  endtask

  task automatic test_avg();
    int cyc;
    do_reset();
    vin[0] = 8'h00; ch_mask = 4'b0001; cont = 1'b0;
    pulse_start();
    cyc = 1;
    while (!valid2 && cyc < 60) begin @(negedge clk); cyc++; end
    checks++;
    if ({valid2, result2, result_ch2} !== {1'b1, 8'h11, 2'd0} || cyc !== 41) begin
      errors++; $display("FAIL avg got v=%b res=%h ch=%0d cyc=%0d exp 1 11 0 41", valid2, result2, result_ch2, cyc);
    end
    @(negedge clk);
    checks++;
    if ({busy2, valid2} !== 2'b00) begin errors++; $display("FAIL avg_end got busy=%b v=%b exp 0 0", busy2, valid2); end
  endtask

  initial begin
    vin = '{8'h0, 8'h0, 8'h0, 8'h0};
    test_reset();
    test_single();
    test_mask();
    test_cont();
    test_reset_mid();
    test_zero_mask();
    test_avg();
    checks++;
    if (dbl !== 0) begin errors++; $display("FAIL valid_double got %0d exp 0", dbl); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
